// File: rtl/fmt_pkg.sv
// rtl/fmt_pkg.sv - shared types and constants for the formatter receiver
package fmt_pkg;

  localparam int unsigned FMT_DW      = 32;
  localparam int unsigned FMT_MAX_LEN = 31;
  localparam int unsigned FMT_LEN_W   = $clog2(FMT_MAX_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_START,
    ST_RECV,
    ST_DRAIN_REQ
  } fmt_rx_state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [1:0]        chid;
    logic [FMT_DW-1:0] data;
  } fmt_rx_word_t;

endpackage

// File: rtl/fmt_rx_fifo.sv
// rtl/fmt_rx_fifo.sv - first-word-fall-through sync FIFO of tagged receive words
module fmt_rx_fifo
  import fmt_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fmt_rx_word_t wdata_i,
  output fmt_rx_word_t rdata_o,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         full_o
);

  fmt_rx_word_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fmt_receiver.sv
// rtl/fmt_receiver.sv - formatter protocol sink: grants on space, buffers packets, streams them out
module fmt_receiver
  import fmt_pkg::*;
#(
  parameter int unsigned DW    = FMT_DW,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 fmt_req_i,
  input  logic [1:0]           fmt_chid_i,
  input  logic [FMT_LEN_W-1:0] fmt_length_i,
  output logic                 fmt_grant_o,
  input  logic [DW-1:0]        fmt_data_i,
  input  logic                 fmt_start_i,
  input  logic                 fmt_end_i,
  output logic                 rx_val_o,
  input  logic                 rx_rdy_i,
  output logic [DW-1:0]        rx_dat_o,
  output logic [1:0]           rx_chid_o,
  output logic                 rx_sop_o,
  output logic                 rx_eop_o,
  output logic                 pkt_done_o,
  output logic                 err_len_o,
  output logic                 err_proto_o,
  output logic [AW:0]          free_o
);

  fmt_rx_state_e        state_q;
  logic [1:0]           chid_q;
  logic [FMT_LEN_W-1:0] len_q, cnt_q;
  logic                 grant_q, done_q, elen_q, eproto_q;
  logic                 push, pop, last_cnt, fifo_empty, fifo_full;
  logic [AW:0]          fifo_count;
  fmt_rx_word_t         wr_word, rd_word;

  assign last_cnt = (cnt_q + 1'b1) == len_q;

  always_comb begin
    push    = 1'b0;
    wr_word = '{sop: (state_q == ST_WAIT_START), eop: 1'b0, chid: chid_q, data: fmt_data_i};
    if (state_q == ST_WAIT_START && fmt_start_i) begin
      push        = 1'b1;
      wr_word.eop = (len_q == 5'd1);
    end else if (state_q == ST_RECV) begin
      push        = 1'b1;
      wr_word.eop = fmt_end_i || last_cnt;
    end
  end

  // Space is reserved once at grant; with one packet in flight it can only grow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      chid_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      done_q   <= 1'b0;
      elen_q   <= 1'b0;
      eproto_q <= 1'b0;
    end else begin
      grant_q  <= 1'b0;
      done_q   <= 1'b0;
      elen_q   <= 1'b0;
      eproto_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fmt_req_i) begin
            if (fmt_length_i == '0) begin
              eproto_q <= 1'b1;
              state_q  <= ST_DRAIN_REQ;
            end else if (free_o >= (AW+1)'(fmt_length_i)) begin
              chid_q  <= fmt_chid_i;
              len_q   <= fmt_length_i;
              grant_q <= 1'b1;
              state_q <= ST_GRANT;
            end
          end
        end
        ST_GRANT: state_q <= ST_WAIT_START;
        ST_WAIT_START: begin
          if (fmt_start_i) begin
            cnt_q <= 5'd1;
            if (len_q == 5'd1) begin
              done_q  <= 1'b1;
              elen_q  <= !fmt_end_i;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          cnt_q    <= cnt_q + 1'b1;
          eproto_q <= fmt_start_i;
          if (wr_word.eop) begin
            done_q  <= 1'b1;
            elen_q  <= !(fmt_end_i && last_cnt);
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN_REQ: if (!fmt_req_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fmt_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_word),
    .rdata_o (rd_word),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && fifo_full && !pop));

  assign rx_val_o    = !fifo_empty;
  assign pop         = rx_val_o && rx_rdy_i;
  assign rx_dat_o    = rd_word.data;
  assign rx_chid_o   = rd_word.chid;
  assign rx_sop_o    = rd_word.sop;
  assign rx_eop_o    = rd_word.eop;
  assign free_o      = (AW+1)'(DEPTH) - fifo_count;
  assign fmt_grant_o = grant_q;
  assign pkt_done_o  = done_q;
  assign err_len_o   = elen_q;
  assign err_proto_o = eproto_q;

endmodule

// File: tb/tb_fmt_receiver.sv
// tb/tb_fmt_receiver.sv - randomized bench for fmt_receiver against a packet-rule model
module tb_fmt_receiver;

  localparam int DEPTH = 64;

  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic        fmt_req_i = 1'b0, fmt_start_i = 1'b0, fmt_end_i = 1'b0, rx_rdy_i = 1'b0;
  logic [1:0]  fmt_chid_i = '0;
  logic [4:0]  fmt_length_i = '0;
  logic [31:0] fmt_data_i = '0;
  logic        fmt_grant_o, rx_val_o, rx_sop_o, rx_eop_o, pkt_done_o, err_len_o, err_proto_o;
  logic [31:0] rx_dat_o;
  logic [1:0]  rx_chid_o;
  logic [6:0]  free_o;

  always #5 clk_i = ~clk_i;

  fmt_receiver #(.DW(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .fmt_req_i(fmt_req_i), .fmt_chid_i(fmt_chid_i),
    .fmt_length_i(fmt_length_i), .fmt_grant_o(fmt_grant_o), .fmt_data_i(fmt_data_i),
    .fmt_start_i(fmt_start_i), .fmt_end_i(fmt_end_i), .rx_val_o(rx_val_o), .rx_rdy_i(rx_rdy_i),
    .rx_dat_o(rx_dat_o), .rx_chid_o(rx_chid_o), .rx_sop_o(rx_sop_o), .rx_eop_o(rx_eop_o),
    .pkt_done_o(pkt_done_o), .err_len_o(err_len_o), .err_proto_o(err_proto_o), .free_o(free_o)
  );

  typedef struct { logic [31:0] d; logic [1:0] c; logic s; logic e; } w_t;

  w_t          mq[$];
  logic [31:0] rx_log[$];
  int          n_cmp = 0, n_bad = 0;
  int          o_done = 0, o_elen = 0, o_ep = 0;
  bit          rnd_rdy = 1'b0;
  bit          m_gnt, m_done, m_elen, m_ep, m_drain, m_wait, m_inpkt;
  bit          n_g, n_d, n_l, n_p, last;
  int          m_need, m_got, sz;
  logic [1:0]  m_chid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of stored words plus the packet in progress; advanced once per clock.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      mq.delete();
      {m_gnt, m_done, m_elen, m_ep, m_drain, m_wait, m_inpkt} = '0;
      m_need = 0; m_got = 0; m_chid = '0;
    end
    sz = mq.size();
    chk("grant", fmt_grant_o, m_gnt);
    chk("pkt_done", pkt_done_o, m_done);
    chk("err_len", err_len_o, m_elen);
    chk("err_proto", err_proto_o, m_ep);
    chk("rx_val", rx_val_o, sz != 0);
    chk("free", free_o, DEPTH - sz);
    if (sz != 0) begin
      chk("rx_dat", rx_dat_o, mq[0].d);
      chk("rx_chid", rx_chid_o, mq[0].c);
      chk("rx_sop", rx_sop_o, mq[0].s);
      chk("rx_eop", rx_eop_o, mq[0].e);
    end
    if (rstn_i) begin
      o_done += int'(pkt_done_o); o_elen += int'(err_len_o); o_ep += int'(err_proto_o);
      if (rx_val_o && rx_rdy_i) rx_log.push_back(rx_dat_o);
      {n_g, n_d, n_l, n_p} = '0;
      if (m_drain) m_drain = fmt_req_i;
      else if (m_gnt) m_wait = 1'b1;
      else if (m_wait || m_inpkt) begin
        if (m_inpkt || fmt_start_i) begin
          m_got = m_inpkt ? m_got + 1 : 1;
          last  = m_inpkt ? (fmt_end_i || m_got == m_need) : (m_need == 1);
          n_p   = m_inpkt && fmt_start_i;
          mq.push_back('{d: fmt_data_i, c: m_chid, s: !m_inpkt, e: last});
          m_inpkt = !last;
          m_wait  = 1'b0;
          if (last) begin n_d = 1'b1; n_l = !(fmt_end_i && m_got == m_need); end
        end
      end else if (fmt_req_i) begin
        if (fmt_length_i == 0) begin n_p = 1'b1; m_drain = 1'b1; end
        else if (DEPTH - sz >= int'(fmt_length_i)) begin
          n_g = 1'b1; m_need = int'(fmt_length_i); m_chid = fmt_chid_i;
        end
      end
      if (sz != 0 && rx_rdy_i) void'(mq.pop_front());
      m_gnt = n_g; m_done = n_d; m_elen = n_l; m_ep = n_p;
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
    if (rnd_rdy) rx_rdy_i = ($urandom_range(3) != 0);
  endtask

  task automatic request(input logic [1:0] ch, input logic [4:0] len, input int budget, output int waited);
    fmt_req_i = 1'b1; fmt_chid_i = ch; fmt_length_i = len; waited = 0;
    do begin cyc(); waited++; end while (!fmt_grant_o && waited < budget);
    fmt_req_i = 1'b0; fmt_chid_i = 2'($urandom); fmt_length_i = 5'($urandom);
    n_cmp++;
    if (!fmt_grant_o) begin
      n_bad++;
      $display("FAIL grant_timeout: no grant after %0d cycles, required within %0d", waited, budget);
    end
  endtask

  task automatic send_words(input int nw, input int end_at, input int st2_at, input int gap,
                            input logic [31:0] base, input bit rnd);
    fmt_start_i = 1'b0; fmt_end_i = 1'b0;
    cyc();
    repeat (gap) begin
      fmt_data_i = $urandom; fmt_end_i = 1'($urandom); cyc();
    end
    for (int i = 1; i <= nw; i++) begin
      fmt_data_i  = rnd ? $urandom : base + 32'(i - 1);
      fmt_start_i = (i == 1) || (i == st2_at);
      fmt_end_i   = (i == end_at);
      cyc();
    end
    fmt_start_i = 1'b0; fmt_end_i = 1'b0; fmt_data_i = '0;
  endtask

  initial begin
    int w, g, d_done, d_elen, d_ep, len, mode, nw, end_at, st2;
    repeat (3) cyc();
    rstn_i = 1'b1;
    cyc();
    chk("reset_free", free_o, 64);
    chk("reset_val", rx_val_o, 0);

    // Normal packet
    rx_rdy_i = 1'b1; rx_log.delete(); d_done = o_done; d_elen = o_elen;
    request(2'd0, 5'd4, 50, w);
    chk("t1_grant_latency", w, 1);
    send_words(4, 4, 0, 0, 32'd10, 1'b0);
    repeat (5) cyc();
    chk("t1_nwords", rx_log.size(), 4);
    for (int i = 0; i < 4 && i < rx_log.size(); i++) chk("t1_data", rx_log[i], 10 + i);
    chk("t1_done", o_done - d_done, 1);
    chk("t1_elen", o_elen - d_elen, 0);

    // Backpressure: 60 words parked, len 8 must wait for four pops
    rx_rdy_i = 1'b0;
    request(2'd1, 5'd30, 50, w); send_words(30, 30, 0, 0, 32'd1000, 1'b0);
    request(2'd2, 5'd30, 50, w); send_words(30, 30, 0, 0, 32'd2000, 1'b0);
    fmt_req_i = 1'b1; fmt_length_i = 5'd8; fmt_chid_i = 2'd3; g = 0;
    repeat (10) begin cyc(); g |= int'(fmt_grant_o); end
    chk("t2_no_grant", g, 0);
    chk("t2_free", free_o, 4);
    rx_rdy_i = 1'b1;
    request(2'd3, 5'd8, 100, w);
    chk("t2_grant_wait", w, 5);
    send_words(8, 8, 0, 0, 32'd3000, 1'b0);
    repeat (70) cyc();

    // Early end
    rx_log.delete(); d_elen = o_elen;
    request(2'd0, 5'd8, 50, w); send_words(5, 5, 0, 0, 32'd100, 1'b0);
    repeat (10) cyc();
    chk("t3_nwords", rx_log.size(), 5);
    chk("t3_elen", o_elen - d_elen, 1);

    // Missing end: trailing words dropped
    rx_log.delete(); d_elen = o_elen; d_done = o_done;
    request(2'd1, 5'd4, 50, w); send_words(6, 0, 0, 0, 32'd200, 1'b0);
    repeat (10) cyc();
    chk("t4_nwords", rx_log.size(), 4);
    chk("t4_elen", o_elen - d_elen, 1);
    chk("t4_done", o_done - d_done, 1);

    // Illegal length held three cycles
    d_ep = o_ep; g = 0;
    fmt_req_i = 1'b1; fmt_length_i = 5'd0;
    repeat (3) begin cyc(); g |= int'(fmt_grant_o); end
    fmt_req_i = 1'b0;
    cyc(); g |= int'(fmt_grant_o);
    chk("t5_no_grant", g, 0);
    chk("t5_eproto", o_ep - d_ep, 1);
    request(2'd2, 5'd4, 50, w);
    chk("t5_regrant_latency", w, 1);
    send_words(4, 4, 0, 0, 32'd300, 1'b0);
    repeat (8) cyc();

    // Reset mid-packet
    rx_rdy_i = 1'b0;
    request(2'd3, 5'd8, 50, w); send_words(2, 0, 0, 0, 32'd400, 1'b0);
    rstn_i = 1'b0;
    #1;
    chk("t6_free", free_o, 64);
    chk("t6_val", rx_val_o, 0);
    cyc();
    rstn_i = 1'b1; rx_rdy_i = 1'b1; rx_log.delete();
    request(2'd1, 5'd3, 50, w); send_words(3, 3, 0, 0, 32'd500, 1'b0);
    repeat (6) cyc();
    chk("t6_nwords", rx_log.size(), 3);
    if (rx_log.size() > 0) chk("t6_first", rx_log[0], 500);

    // Randomized traffic
    rnd_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 31); mode = $urandom_range(0, 5);
      nw = len; end_at = len;
      if (mode == 3 && len > 1) begin
        end_at = $urandom_range(2, len); nw = end_at + $urandom_range(0, 2);
      end else if (mode == 4) begin
        end_at = 0; nw = len + $urandom_range(0, 2);
      end
      st2 = ($urandom_range(9) == 0) ? $urandom_range(2, 32) : 0;
      if (mode == 5) begin
        fmt_req_i = 1'b1; fmt_length_i = 5'd0;
        repeat ($urandom_range(1, 4)) cyc();
        fmt_req_i = 1'b0; cyc();
      end else begin
        request(2'($urandom), 5'(len), 500, w);
        send_words(nw, end_at, st2, $urandom_range(0, 3), 32'd0, 1'b1);
      end
      repeat ($urandom_range(0, 3)) cyc();
    end
    rnd_rdy = 1'b0; rx_rdy_i = 1'b1;
    repeat (80) cyc();
    chk("final_free", free_o, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
